// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pulls bytes from a registered-output FIFO and packs LANES of
// them into one word (lane 0 = first byte) behind a ready/valid output register.
// Optional build macro PACK_FLUSH_EN: flush a partial word after TIMEOUT idle
// cycles, with m_keep_o marking the filled lanes. Without it, partial words
// are held until they fill and m_keep_o is all-ones on every load.
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [WIDTH-1:0]         fifo_rdata_i,
  input  logic                     fifo_empty_i,
  input  logic                     fifo_rd_error_i,
  output logic                     fifo_rd_en_o,
  output logic [WIDTH*LANES-1:0]   m_data_o,
  output logic [LANES-1:0]         m_keep_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     err_o
);

  localparam int CW = $clog2(LANES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef PACK_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic [WIDTH-1:0]       pack_reg [LANES];
  logic [CW-1:0]          cnt_reg;
  logic                   pend_reg;
  logic [WIDTH*LANES-1:0] m_data_reg;
  logic [LANES-1:0]       m_keep_reg;
  logic                   m_valid_reg;
  logic                   err_reg;
  logic [TW-1:0]          idle_reg;

  logic                   rd_en;
  logic                   load;
  logic                   flush_req;
  logic                   idle_hit;
  logic [CW:0]            occupancy;
  logic [CW-1:0]          wr_lane;
  logic [WIDTH*LANES-1:0] pack_masked;
  logic [LANES-1:0]       keep_fill;
  logic [LANES-1:0]       keep_load;

  // Bytes already captured plus the one still on its way from the FIFO.
  assign occupancy = {1'b0, cnt_reg} + {{CW{1'b0}}, pend_reg};

  // Read only when there is room for the byte; a pending flush freezes reads
  // so the partial word cannot grow while it is being emitted.
  assign rd_en = rst_n_i & ~fifo_empty_i & (occupancy < (CW+1)'(LANES)) & ~flush_req;

  // Move the pack register to the output stage when full (or flushing) and
  // the output stage is empty or being drained on this edge.
  assign load = ((cnt_reg == CW'(LANES)) | flush_req) & (~m_valid_reg | m_ready_i);

  // A byte arriving on a load edge starts the next word in lane 0.
  assign wr_lane = load ? '0 : cnt_reg;

  assign idle_hit  = (idle_reg == TW'(TIMEOUT));
  assign flush_req = FLUSH_EN & idle_hit;
  assign keep_load = FLUSH_EN ? keep_fill : '1;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign keep_fill[gi] = (CW'(gi) < cnt_reg);
      assign pack_masked[gi*WIDTH +: WIDTH] = keep_fill[gi] ? pack_reg[gi] : '0;

      // Capture the returning FIFO byte into its lane.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          pack_reg[gi] <= '0;
        end else if (pend_reg && (wr_lane == CW'(gi))) begin
          pack_reg[gi] <= fifo_rdata_i;
        end
      end
    end
  endgenerate

  // Track the in-flight read and the number of captured lanes.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= rd_en;
      if (load) begin
        cnt_reg <= CW'(pend_reg);
      end else if (pend_reg) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  // Output register: load a packed word, drop valid once accepted, else hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_data_reg  <= '0;
      m_keep_reg  <= '0;
      m_valid_reg <= 1'b0;
    end else if (load) begin
      m_data_reg  <= pack_masked;
      m_keep_reg  <= keep_load;
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready_i) begin
      m_valid_reg <= 1'b0;
    end
  end

  // Idle counter: runs while a started word waits on an empty FIFO, saturating
  // at TIMEOUT so the flush request stays up until the word can be loaded.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idle_reg <= '0;
    end else if (load) begin
      idle_reg <= '0;
    end else if ((cnt_reg != '0) && !pend_reg && fifo_empty_i) begin
      if (!idle_hit) begin
        idle_reg <= idle_reg + TW'(1);
      end
    end else begin
      idle_reg <= '0;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_reg <= 1'b0;
    end else if (fifo_rd_error_i) begin
      err_reg <= 1'b1;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_data_o     = m_data_reg;
  assign m_keep_o     = m_keep_reg;
  assign m_valid_o    = m_valid_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: randomized and directed checks of fifo_rd_packer against
// a behavioural FIFO model and byte-order word expectations (LANES=4, WIDTH=8).
module tb_fifo_rd_packer;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_n_i         = 1'b0;
  logic [W-1:0]   fifo_rdata_i    = '0;
  logic           fifo_empty_i    = 1'b1;
  logic           fifo_rd_error_i = 1'b0;
  logic           m_ready_i       = 1'b0;
  logic           fifo_rd_en_o;
  logic [W*L-1:0] m_data_o;
  logic [L-1:0]   m_keep_o;
  logic           m_valid_o;
  logic           err_o;

  fifo_rd_packer #(.WIDTH(W), .LANES(L), .TIMEOUT(TO)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .fifo_rdata_i    (fifo_rdata_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_error_i (fifo_rd_error_i),
    .fifo_rd_en_o    (fifo_rd_en_o),
    .m_data_o        (m_data_o),
    .m_keep_o        (m_keep_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .err_o           (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model storage: tasks write at wr_ptr, the model reads at rd_ptr
  logic [7:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc    = 0;
  logic rd_take = 1'b0;

  // Monitor records
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  int          rise_cyc [$];
  int          rd_cyc   [$];
  int          empty_viol  = 0;
  int          stable_viol = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = '0;
  logic [3:0]  prev_k = '0;

  // FIFO model: data registered one cycle after a read, empty flag from contents
  always @(posedge clk_i) begin
    cyc++;
    if (rd_take && (rd_ptr < wr_ptr)) begin
      fifo_rdata_i <= fifo_mem[rd_ptr];
      rd_ptr++;
    end
    #1 fifo_empty_i = (rd_ptr == wr_ptr);
  end

  // Monitor on the falling edge: reads, accepted words, protocol observations
  always @(negedge clk_i) begin
    rd_take = (fifo_rd_en_o === 1'b1);
    if (rd_take) rd_cyc.push_back(cyc);
    if (rd_take && fifo_empty_i) empty_viol++;
    if (prev_v && !prev_r && (m_valid_o !== 1'b1 || m_data_o !== prev_d || m_keep_o !== prev_k))
      stable_viol++;
    if (m_valid_o === 1'b1 && !prev_v) rise_cyc.push_back(cyc);
    if (m_valid_o === 1'b1 && m_ready_i) begin
      got_data.push_back(m_data_o);
      got_keep.push_back(m_keep_o);
      $display("word %0d: data=%h keep=%h cycle=%0d", got_data.size(), m_data_o, m_keep_o, cyc);
    end
    prev_v = (m_valid_o === 1'b1);
    prev_r = m_ready_i;
    prev_d = m_data_o;
    prev_k = m_keep_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    int base;
    rst_n_i   = 1'b0;
    m_ready_i = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (4) tick();
    n_checks++; if (fifo_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en_o); end
    n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid_o); end
    n_checks++; if (m_keep_o !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %h expected 0", m_keep_o); end
    n_checks++; if (m_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", m_data_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
    base = got_data.size();
    rst_n_i = 1'b1;
    wait_words(base + 1, 50);
    n_checks++;
    if (got_data.size() < base + 1) begin n_fail++; $display("FAIL reset_release_word: got %0d words expected %0d", got_data.size() - base, 1); end
    else if (got_data[base] !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL reset_release_word: got %h expected a3a2a1a0", got_data[base]); end
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int base, cb, rb;
    base = got_data.size(); cb = rd_cyc.size(); rb = rise_cyc.size();
    m_ready_i = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words(base + 1, 50);
    repeat (2) tick();
    n_checks++;
    if (got_data.size() < base + 1) begin n_fail++; $display("FAIL basic_data: got %0d words expected 1", got_data.size() - base); end
    else if (got_data[base] !== 32'h44332211) begin n_fail++; $display("FAIL basic_data: got %h expected 44332211", got_data[base]); end
    n_checks++;
    if (got_keep.size() < base + 1 || got_keep[base] !== 4'hF) begin n_fail++; $display("FAIL basic_keep: got %h expected f", (got_keep.size() > base) ? got_keep[base] : 4'hX); end
    n_checks++;
    if (rd_cyc.size() - cb != 4) begin n_fail++; $display("FAIL basic_reads: got %0d expected 4", rd_cyc.size() - cb); end
    else if (rd_cyc[cb+3] - rd_cyc[cb] != 3) begin n_fail++; $display("FAIL basic_back_to_back: got span %0d expected 3", rd_cyc[cb+3] - rd_cyc[cb]); end
    n_checks++;
    if (rise_cyc.size() <= rb || rd_cyc.size() - cb < 4) begin n_fail++; $display("FAIL basic_latency: got no valid rise expected 3 cycles"); end
    else if (rise_cyc[rb] - rd_cyc[cb+3] != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", rise_cyc[rb] - rd_cyc[cb+3]); end
    n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clear: got %b expected 0", m_valid_o); end
  endtask

  task automatic test_backpressure();
    int base, cb, sv;
    logic [31:0] exp_w;
    base = got_data.size(); cb = rd_cyc.size(); sv = stable_viol;
    m_ready_i = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (25) tick();
    n_checks++; if (rd_cyc.size() - cb != 8) begin n_fail++; $display("FAIL bp_reads_stalled: got %0d expected 8", rd_cyc.size() - cb); end
    n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h04030201) begin n_fail++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=04030201", m_valid_o, m_data_o); end
    n_checks++; if (got_data.size() != base) begin n_fail++; $display("FAIL bp_no_accept: got %0d words expected 0", got_data.size() - base); end
    m_ready_i = 1'b1;
    wait_words(base + 3, 60);
    for (int w = 0; w < 3; w++) begin
      exp_w = '0;
      for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'(4*w + j + 1);
      n_checks++;
      if (got_data.size() < base + w + 1) begin n_fail++; $display("FAIL bp_word%0d: missing, expected %h", w, exp_w); end
      else if (got_data[base+w] !== exp_w) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", w, got_data[base+w], exp_w); end
    end
    n_checks++; if (stable_viol != sv) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_viol - sv); end
    repeat (3) tick();
  endtask

  task automatic test_error();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b expected 0", err_o); end
    fifo_rd_error_i = 1'b1;
    tick();
    fifo_rd_error_i = 1'b0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_o); end
    repeat (10) tick();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    rst_n_i = 1'b0;
    tick();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b expected 0", err_o); end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_midword();
    int base, cb, k;
    base = got_data.size(); cb = rd_cyc.size(); k = 0;
    m_ready_i = 1'b1;
    push(8'h55); push(8'h66); push(8'h77);
    while (rd_cyc.size() < cb + 3 && k < 30) begin tick(); k++; end
    repeat (3) tick();
    n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL midword_no_word: got valid=%b expected 0", m_valid_o); end
    rst_n_i = 1'b0;
    repeat (2) tick();
    n_checks++; if (m_valid_o !== 1'b0 || m_keep_o !== 4'h0) begin n_fail++; $display("FAIL midword_reset: got valid=%b keep=%h expected 0/0", m_valid_o, m_keep_o); end
    rst_n_i = 1'b1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    wait_words(base + 1, 50);
    repeat (3) tick();
    n_checks++;
    if (got_data.size() != base + 1) begin n_fail++; $display("FAIL midword_fresh: got %0d words expected 1", got_data.size() - base); end
    else if (got_data[base] !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL midword_fresh: got %h expected c4c3c2c1", got_data[base]); end
  endtask

`ifdef PACK_FLUSH_EN
  task automatic test_flush();
    int base;
    base = got_data.size();
    m_ready_i = 1'b1;
    push(8'hAA); push(8'hBB);
    wait_words(base + 1, 80);
    n_checks++;
    if (got_data.size() < base + 1) begin n_fail++; $display("FAIL flush_data: got no word expected 0000bbaa"); end
    else if (got_data[base] !== 32'h0000BBAA) begin n_fail++; $display("FAIL flush_data: got %h expected 0000bbaa", got_data[base]); end
    n_checks++;
    if (got_keep.size() < base + 1 || got_keep[base] !== 4'h3) begin n_fail++; $display("FAIL flush_keep: got %h expected 3", (got_keep.size() > base) ? got_keep[base] : 4'hX); end
    repeat (3) tick();
  endtask
`else
  task automatic test_partial_hold();
    int base;
    base = got_data.size();
    m_ready_i = 1'b1;
    push(8'h21); push(8'h22);
    repeat (40) tick();
    n_checks++; if (got_data.size() != base || m_valid_o !== 1'b0) begin n_fail++; $display("FAIL partial_held: got %0d words valid=%b expected 0/0", got_data.size() - base, m_valid_o); end
    push(8'h23); push(8'h24);
    wait_words(base + 1, 40);
    n_checks++;
    if (got_data.size() < base + 1) begin n_fail++; $display("FAIL partial_complete: got no word expected 24232221"); end
    else if (got_data[base] !== 32'h24232221 || got_keep[base] !== 4'hF) begin n_fail++; $display("FAIL partial_complete: got %h/%h expected 24232221/f", got_data[base], got_keep[base]); end
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    logic [7:0]  rb [32];
    logic [31:0] exp_w;
    int pushed = 0;
    int since  = 0;
    int k      = 0;
    int base, sv, ev;
    base = got_data.size(); sv = stable_viol; ev = empty_viol;
    while ((pushed < 32 || got_data.size() < base + 8) && k < 3000) begin
      if (pushed < 32 && ($urandom_range(0, 1) == 1 || since >= 6)) begin
        rb[pushed] = 8'($urandom);
        push(rb[pushed]);
        pushed++;
        since = 0;
      end else begin
        since++;
      end
      m_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    m_ready_i = 1'b1;
    repeat (3) tick();
    n_checks++; if (got_data.size() != base + 8) begin n_fail++; $display("FAIL rand_count: got %0d words expected 8", got_data.size() - base); end
    for (int w = 0; w < 8; w++) begin
      exp_w = '0;
      for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = rb[4*w + j];
      n_checks++;
      if (got_data.size() < base + w + 1) begin n_fail++; $display("FAIL rand_word%0d: missing, expected %h", w, exp_w); end
      else if (got_data[base+w] !== exp_w || got_keep[base+w] !== 4'hF) begin n_fail++; $display("FAIL rand_word%0d: got %h/%h expected %h/f", w, got_data[base+w], got_keep[base+w], exp_w); end
    end
    n_checks++; if (stable_viol != sv) begin n_fail++; $display("FAIL rand_stable: got %0d unstable cycles expected 0", stable_viol - sv); end
    n_checks++; if (empty_viol != ev) begin n_fail++; $display("FAIL rand_rd_when_empty: got %0d expected 0", empty_viol - ev); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_reset_midword();
`ifdef PACK_FLUSH_EN
    test_flush();
`else
    test_partial_hold();
`endif
    test_random();
    n_checks++; if (empty_viol != 0) begin n_fail++; $display("FAIL rd_en_while_empty: got %0d expected 0", empty_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
